// File: rtl/traffic_request_arbiter_pkg.sv
// Shared types and helpers for the traffic request arbiter.
package traffic_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  function automatic lane_e next_lane(input lane_e l);
    case (l)
      LANE_A:  next_lane = LANE_B;
      LANE_B:  next_lane = LANE_C;
      LANE_C:  next_lane = LANE_D;
      default: next_lane = LANE_A;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_oh(input lane_e l);
    lane_oh    = '0;
    lane_oh[l] = 1'b1;
  endfunction

endpackage

// File: rtl/traffic_request_arbiter_debounce.sv
// Single-lane sensor conditioning: 2-flop synchroniser, debounce counter and
// a one-cycle pulse on each accepted rising level.
module lane_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          synced;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
      rise   <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
        rise   <= synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_request_arbiter.sv
// Round-robin lane arbiter feeding the traffic light controller.
// Optional preemption input set enabled by TRAFFIC_PREEMPT_EN.
//
// state | meaning
// IDLE  | no grant; waits for any pending request
// GRANT | one switch_to_* high for MIN_GREEN_CYCLES
// CLEAR | all switch_to_* low for CLEAR_CYCLES
module traffic_request_arbiter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int CLEAR_CYCLES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] sensor,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                 preempt_req,
  input  logic [1:0]           preempt_lane,
`endif
  output logic                 switch_to_a,
  output logic                 switch_to_b,
  output logic                 switch_to_c,
  output logic                 switch_to_d,
  output logic [NUM_LANES-1:0] pending,
  output logic                 busy
);

  localparam int TMAX = (MIN_GREEN_CYCLES > CLEAR_CYCLES) ? MIN_GREEN_CYCLES : CLEAR_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] GREEN_LOAD = TW'(MIN_GREEN_CYCLES - 1);
  localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 1);

  logic [NUM_LANES-1:0] rise;
  logic [NUM_LANES-1:0] grant_oh;
  logic [NUM_LANES-1:0] clr_mask;
  logic [TW-1:0]        timer;
  arb_state_e           state;
  lane_e                last_lane;
  lane_e                cur_lane;
  lane_e                sel_lane;
  lane_e                pre_lane;
  logic                 pre_go;
  logic                 grant_now;
  lane_e                grant_lane;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .raw  (sensor[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
`ifdef TRAFFIC_PREEMPT_EN
    pre_go   = preempt_req;
    pre_lane = lane_e'(preempt_lane);
`else
    pre_go   = 1'b0;
    pre_lane = LANE_A;
`endif
  end

  // First pending lane after last_lane, wrapping round to last_lane itself.
  always_comb begin
    lane_e cand;
    logic  found;
    cand     = last_lane;
    found    = 1'b0;
    sel_lane = last_lane;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = next_lane(cand);
      if (!found && pending[cand]) begin
        sel_lane = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_now  = pre_go || (state == IDLE && pending != '0);
    grant_lane = pre_go ? pre_lane : sel_lane;
    clr_mask   = '0;
    if (grant_now)      clr_mask = clr_mask | lane_oh(grant_lane);
    if (state == GRANT) clr_mask = clr_mask | grant_oh;
  end

  // Clear beats set, so an edge on the lane being served is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= (pending | rise) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      last_lane <= LANE_D;
      cur_lane  <= LANE_A;
      grant_oh  <= '0;
      busy      <= 1'b0;
    end else if (pre_go) begin
      state    <= GRANT;
      cur_lane <= pre_lane;
      grant_oh <= lane_oh(pre_lane);
      timer    <= GREEN_LOAD;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            state    <= GRANT;
            cur_lane <= sel_lane;
            grant_oh <= lane_oh(sel_lane);
            timer    <= GREEN_LOAD;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (timer == '0) begin
            state     <= CLEAR;
            last_lane <= cur_lane;
            timer     <= CLEAR_LOAD;
            grant_oh  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        CLEAR: begin
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          grant_oh <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  assign switch_to_a = grant_oh[0];
  assign switch_to_b = grant_oh[1];
  assign switch_to_c = grant_oh[2];
  assign switch_to_d = grant_oh[3];

endmodule

// File: tb/tb_traffic_request_arbiter.sv
// Directed, table-driven bench for traffic_request_arbiter.
module tb_traffic_request_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensor;
  logic       sw_a, sw_b, sw_c, sw_d;
  logic [3:0] pending;
  logic       busy;
  logic [3:0] sw;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt_req;
  logic [1:0] preempt_lane;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] sw_log   [0:40];
  logic [3:0] pend_log [0:40];
  logic       busy_log [0:40];
  int         multi_hot;

  typedef struct {
    logic [3:0] sens;
    logic [3:0] first;
    logic [3:0] second;
  } vec_t;
  vec_t vecs [8];

  traffic_request_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .sensor      (sensor),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt_req (preempt_req),
    .preempt_lane(preempt_lane),
`endif
    .switch_to_a (sw_a),
    .switch_to_b (sw_b),
    .switch_to_c (sw_c),
    .switch_to_d (sw_d),
    .pending     (pending),
    .busy        (busy)
  );

  assign sw = {sw_d, sw_c, sw_b, sw_a};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      sw_log[i]   = sw;
      pend_log[i] = pending;
      busy_log[i] = busy;
      if ($countones(sw) > 1) multi_hot++;
    end
  endtask

  // 20 ns reset, then release and apply s on the same negedge.
  task automatic start(input logic [3:0] s);
    @(negedge clk);
    rst    = 1'b0;
    sensor = 4'b0000;
    #1;
    chk("reset_state", {23'd0, sw, pending, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    sensor = s;
  endtask

  initial begin
    int on_cnt;
    int bad;
    rst    = 1'b0;
    sensor = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
    preempt_req  = 1'b0;
    preempt_lane = 2'd0;
`endif
    multi_hot = 0;

    vecs[0] = '{4'b0001, 4'b0001, 4'b0000};
    vecs[1] = '{4'b0010, 4'b0010, 4'b0000};
    vecs[2] = '{4'b0100, 4'b0100, 4'b0000};
    vecs[3] = '{4'b1000, 4'b1000, 4'b0000};
    vecs[4] = '{4'b0101, 4'b0001, 4'b0100};
    vecs[5] = '{4'b1010, 4'b0010, 4'b1000};
    vecs[6] = '{4'b1001, 4'b0001, 4'b1000};
    vecs[7] = '{4'b1111, 4'b0001, 4'b0010};

    // Table: raw step at release; grant at +8, 8 green, 2 clear, 1 idle.
    for (int v = 0; v < 8; v++) begin
      start(vecs[v].sens);
      capture(30);
      chk("pend_set",   pend_log[7], vecs[v].sens);
      chk("pend_clr",   pend_log[8], vecs[v].sens & ~vecs[v].first);
      chk("sw_before",  sw_log[7],   4'b0000);
      chk("sw_first",   sw_log[8],   vecs[v].first);
      chk("sw_first_end", sw_log[15], vecs[v].first);
      chk("sw_clear",   sw_log[16],  4'b0000);
      chk("busy_clear", busy_log[17], 1'b1);
      chk("busy_idle",  busy_log[18], 1'b0);
      chk("sw_idle",    sw_log[18],  4'b0000);
      chk("sw_second",  sw_log[19],  vecs[v].second);
      chk("sw_second_end", sw_log[26], vecs[v].second);
      chk("sw_after",   sw_log[27],  4'b0000);
      chk("pend_after", pend_log[19], vecs[v].sens & ~vecs[v].first & ~vecs[v].second);
      on_cnt = 0;
      for (int i = 1; i <= 30; i++) if (sw_log[i] == vecs[v].first) on_cnt++;
      chk("first_len", on_cnt, 8);
    end

    // Two-cycle glitch on lane A must never be accepted.
    start(4'b0000);
    capture(3);
    sensor = 4'b0001;
    capture(2);
    sensor = 4'b0000;
    capture(20);
    bad = 0;
    for (int i = 1; i <= 20; i++) if (sw_log[i] != 0 || pend_log[i] != 0) bad++;
    chk("glitch_rejected", bad, 0);

    // After B served, A+B -> A then B; then A+D -> D then A.
    start(4'b0010);
    capture(20);
    chk("b_served", sw_log[8], 4'b0010);
    sensor = 4'b0000;
    capture(10);
    sensor = 4'b0011;
    capture(30);
    chk("rr_ab_first",  sw_log[8],  4'b0001);
    chk("rr_ab_second", sw_log[19], 4'b0010);
    sensor = 4'b0000;
    capture(12);
    sensor = 4'b1001;
    capture(30);
    chk("rr_ad_first",  sw_log[8],  4'b1000);
    chk("rr_ad_second", sw_log[19], 4'b0001);

    // Reset three cycles into a D grant drops everything immediately.
    start(4'b1000);
    capture(2);
    sensor = 4'b1001;
    capture(9);
    chk("pre_rst_sw",   sw,      4'b1000);
    chk("pre_rst_pend", pending, 4'b0001);
    rst = 1'b0;
    #1;
    chk("rst_sw",   sw,      4'b0000);
    chk("rst_busy", busy,    1'b0);
    chk("rst_pend", pending, 4'b0000);
    sensor = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    capture(20);
    bad = 0;
    for (int i = 1; i <= 20; i++) if (sw_log[i] != 0 || pend_log[i] != 0 || busy_log[i] != 0) bad++;
    chk("no_grant_after_rst", bad, 0);

`ifdef TRAFFIC_PREEMPT_EN
    // Preempt a B grant with lane C for one cycle.
    start(4'b0010);
    capture(10);
    chk("pre_b_grant", sw_log[10], 4'b0010);
    preempt_req  = 1'b1;
    preempt_lane = 2'd2;
    @(negedge clk);
    preempt_req  = 1'b0;
    chk("preempt_c_on", sw, 4'b0100);
    capture(8);
    chk("preempt_c_hold", sw_log[7], 4'b0100);
    chk("preempt_c_off",  sw_log[8], 4'b0000);
`endif

    chk("one_hot", multi_hot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_arbiter.md
Name: traffic_request_arbiter

Overview:
- Upstream stage of the four-way traffic light controller. Produces its switch_to_a..switch_to_d request levels.
- Takes four raw, asynchronous vehicle-sensor inputs (lanes A..D). Each input is synchronised, debounced and latched as a pending request.
- Grants one lane at a time, round-robin, and holds each grant for a minimum green period. An all-low clearance gap follows every grant.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synced cycles required to accept a sensor level change (≥2).
- MIN_GREEN_CYCLES, 8: cycles a granted switch_to_* stays high (≥1).
- CLEAR_CYCLES, 2: all-low cycles after each grant (≥1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted, 1 = run).
- sensor  in  4  raw lane sensors; bit0=A, bit1=B, bit2=C, bit3=D; asynchronous to clk.
- switch_to_a  out  1  lane A granted; level, held for the whole grant.
- switch_to_b  out  1  lane B granted.
- switch_to_c  out  1  lane C granted.
- switch_to_d  out  1  lane D granted.
- pending  out  4  latched, not-yet-served requests, same bit order as sensor.
- busy  out  1  high in GRANT or CLEAR.

Behaviour:
- Reset (async, rst=0): every flop clears immediately.
  - switch_to_* = 0, pending = 0, busy = 0.
  - Sync and debounce stages = 0; all counters = 0.
  - FSM = IDLE; last_lane = D, so lane A has first priority.
  - Reset release is synchronous to clk.
- Synchroniser: 2-flop chain per lane.
- Debounce, per lane:
  - Counter resets whenever synced == stable.
  - While synced != stable the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and still differing, stable <= synced and counter <= 0.
  - A pulse shorter than DEBOUNCE_CYCLES synced cycles is never accepted.
- Request latch:
  - A rising edge of stable[i] sets pending[i] on the next clock.
  - pending[i] clears in the cycle lane i's grant is registered.
  - Set and clear in the same cycle for the same lane: clear wins. A rising edge on the granted lane during its own GRANT is dropped.
  - Falling edges are ignored.
- FSM states:
  - IDLE: if pending != 0, select the first pending lane scanning last_lane+1, +2, +3, +4 (mod 4). Register the grant and load the timer with MIN_GREEN_CYCLES-1; go to GRANT. Otherwise stay.
  - GRANT: exactly one switch_to_* high (one-hot, never two). Timer decrements; at 0, last_lane <= granted lane, timer <= CLEAR_CYCLES-1; go to CLEAR.
  - CLEAR: all switch_to_* low. At timer 0, go to IDLE.
- Latency:
  - Debounced edge → pending visible at +1 cycle.
  - If IDLE, switch_to_* high at +2 cycles.
  - Raw sensor step → switch_to_* high in 2 + DEBOUNCE_CYCLES + 2 cycles (8 with defaults).
- Simultaneous new requests resolve purely by round-robin order; no lane is granted twice while another is pending.
- Timer width: $clog2(max(MIN_GREEN_CYCLES, CLEAR_CYCLES)) + 1; no wrap is possible.
- Reset asserted mid-GRANT or mid-CLEAR: outputs drop to 0 in the same instant; all pending requests are lost.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN.
- Defined:
  - Adds ports preempt_req in 1 (already synchronous) and preempt_lane in 2.
  - preempt_req high in any state forces GRANT to preempt_lane next cycle, with timer reloaded to MIN_GREEN_CYCLES-1. No CLEAR is inserted, but the outputs remain one-hot.
  - pending[preempt_lane] clears; last_lane is unchanged.
  - While preempt_req is held, GRANT persists and the timer stays reloaded.
- Undefined: ports are absent; pure round-robin behaviour.

Decomposition:
- Package traffic_pkg:
  - lane_e enum (LANE_A=0..LANE_D=3).
  - arb_state_e enum (IDLE, GRANT, CLEAR).
  - localparam NUM_LANES=4.
  - next_lane(lane_e) function.
- One sub-module, lane_debounce: 2-flop synchroniser, debounce counter and rising-edge pulse for a single lane, parameterised by DEBOUNCE_CYCLES. Instantiated 4×.
- Arbiter, timer and FSM stay in the top module.

Test Plan:
1. Reset low 20 ns, release; sensor=4'b0010 held → switch_to_b high 8 cycles after first sampling edge, for exactly 8 cycles, then 2 cycles all low; pending[1] cleared at grant.
2. sensor[0] glitch high for 2 clk cycles → pending stays 0, no switch_to_* ever asserts.
3. Reset release, sensor=4'b0101 same cycle → A granted first, then C after A's 8 green + 2 clear cycles; never both high.
4. After B served (last_lane=B), raise A and B together → C/D skipped (not pending), A granted, then B.
5. Assert rst=0 three cycles into a D grant → switch_to_d, busy, pending all 0 within the same timestep, before the next clock edge; after release, no grant without a new debounced edge.
6. (TRAFFIC_PREEMPT_EN) During a B grant, preempt_req=1 with preempt_lane=2 for 1 cycle → switch_to_b low and switch_to_c high next cycle, for 8 cycles.
